// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// With SKID_EN=1, in_ready comes only from state flops, qualified by reset, which breaks
// the ready path between stages. With SKID_EN=0 it is a single register with
// pass-through ready.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH     = 178,
    parameter bit                SKID_EN   = 1'b1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [15:0]      stall_q, stall_d;
    logic             accept;
    logic             consume;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    // Skid mode keeps ready off the downstream path; held low while in reset.
    assign in_ready = SKID_EN ? (rst & (state_q != StSkid)) : (~out_valid | out_ready);

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // Next-state and payload steering; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Only reachable with the skid entry; single mode needs consume to accept.
                        if (SKID_EN) begin
                            skid_d  = in_data;
                            state_d = StSkid;
                        end
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = StFull;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // Back-pressure counter, saturating, cleared by flush.
    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State and payload registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule
